uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
//   Asynchronous UART receiver (8N1, LSB first) that turns the serial rx pin into a byte stream.
//   Sits directly upstream of the frame parser: rx_data/rx_valid drive the parser's indata.
//   The parser receives one byte per rx_valid pulse (frame 52 0E 01 d0..d7 chk 9A).
//   Reports framing (and optionally parity) errors so upper logic can drop the frame.
// PARAMETERS
//   CLK_HZ        50_000_000  system clock frequency, Hz
//   BAUD          115_200     line rate, bit/s
//   CLKS_PER_BIT  CLK_HZ/BAUD integer clocks per bit (434 at defaults); must be >= 4
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  synchronous reset, active-high
//   rx         in   1  asynchronous serial input, idle high
//   rx_data    out  8  last received byte, held until next valid byte
//   rx_valid   out  1  one-cycle strobe: rx_data updated this cycle
//   frame_err  out  1  one-cycle strobe: stop bit sampled low
//   parity_err out  1  one-cycle strobe: parity mismatch (PARITY_EN only)
//   busy       out  1  high from start-bit detection until return to IDLE
// BEHAVIOUR
//   - Reset (rst=1 on a clk edge): state=IDLE, rx_data=8'h00, all strobes 0, busy=0.
//     Synchronizer flops preset to 1. Reset mid-byte aborts; the partial byte is discarded.
//   - rx passes a 2-flop synchronizer (rx_s); all decisions use rx_s. This adds 2 cycles of latency.
//   - Bit timer: counts 0..CLKS_PER_BIT-1, reloads at each bit boundary; bit index 0..7.
//   - FSM:
//     IDLE  : busy=0; rx_s==0 -> START, timer=0.
//     START : at timer==CLKS_PER_BIT/2-1 (mid start bit), sample rx_s:
//             1 -> glitch, back to IDLE, no strobe; 0 -> DATA, timer=0, idx=0.
//     DATA  : at timer==CLKS_PER_BIT-1 sample rx_s into shift reg bit idx (LSB first).
//             After idx==7 -> PARITY if PARITY_EN, else STOP.
//     PARITY: one bit period; sample the parity bit; compare to even parity of the data.
//     STOP  : at timer==CLKS_PER_BIT-1 sample rx_s:
//             1 -> rx_data<=shift, rx_valid=1 next cycle, IDLE;
//             0 -> frame_err=1 next cycle, rx_data unchanged, BREAK.
//     BREAK : wait until rx_s==1, then IDLE (a held-low line never creates bytes).
//   - Parity mismatch with a good stop: parity_err=1 and rx_valid=0, rx_data unchanged.
//   - Bad stop bit: frame_err only, even if parity is also wrong.
//   - Strobes are mutually exclusive and never longer than one cycle.
//   - busy=1 in every state except IDLE.
//   - Latency: rx falling edge -> rx_valid ~ 2 + (9.5+P)*CLKS_PER_BIT cycles (P=1 with parity).
//   - Back-to-back frames: a start bit immediately after the stop-bit sample is accepted.
//     IDLE is re-entered the cycle after the sample, so no byte is lost.
//   - Counters are sized to hold CLKS_PER_BIT-1; no wrap-around is possible within a bit.
// CONFIGURATION
//   PARITY_EN defined: 8E1 format; PARITY state present; even parity is checked; parity_err is live.
//   PARITY_EN undefined: 8N1 format; no PARITY state; parity_err tied 0.
// TESTING   (CLKS_PER_BIT=16 for the bench)
//   1. Send 0x52 8N1 -> one rx_valid pulse with rx_data=0x52; frame_err=0; busy falls after.
//   2. Send 52 0E 01 11 22 33 44 55 66 77 88 xx 9A back-to-back, no idle gap.
//      -> 13 rx_valid pulses with matching bytes, none dropped.
//   3. Pull rx low for 4 clks, then high (glitch) -> back to IDLE; no strobe; busy pulses only.
//   4. Send 0xA5 with the stop bit forced 0, hold low 40 clks -> frame_err pulse once.
//      rx_data keeps its prior value; no rx_valid until rx returns high and a new byte arrives.
//   5. Assert rst at data bit 4 of 0x3C, then send 0x0E -> only rx_data=0x0E is reported.
//   6. PARITY_EN: send 0x0E with parity 0 (wrong) -> parity_err=1, rx_valid=0.
//      Send 0x0E with parity 1 -> rx_valid=1, rx_data=0x0E.

Source files
------------

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver (LSB first) with 2-flop rx synchronizer and mid-bit sampling.
// Define PARITY_EN for 8E1 framing with even-parity checking on parity_err.
module uart_byte_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  // state  | meaning
  // IDLE   | line idle, waiting for a low rx_s
  // START  | timing to the middle of the start bit, rejects glitches
  // DATA   | sampling 8 data bits, LSB first
  // PARITY | sampling the even-parity bit (PARITY_EN builds only)
  // STOP   | sampling the stop bit, issuing the result strobe
  // BREAK  | stop bit was low; wait for the line to return high
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t          state;
  logic            rx_m;
  logic            rx_s;
  logic [TW-1:0]   timer;
  logic [2:0]      idx;
  logic [7:0]      shift;
`ifdef PARITY_EN
  logic            par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            idx   <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == T_FULL) begin
            timer      <= '0;
            shift[idx] <= rx_s;
            if (idx == 3'd7) begin
`ifdef PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (timer == T_FULL) begin
            timer   <= '0;
            par_bad <= rx_s ^ (^shift);
            state   <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end
`else
              rx_data  <= shift;
              rx_valid <= 1'b1;
`endif
            end else begin
              // Framing error wins over parity; rx_data keeps the last good byte.
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: an event-queue model predicts each result strobe,
// its data and its arrival cycle; a negedge compare process checks the DUT every cycle.
module tb_uart_byte_rx;
  localparam int N = 16;
`ifdef PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = 2 + (19 * N) / 2 + P * N;

  localparam int K_VALID = 0;
  localparam int K_FRAME = 1;
  localparam int K_PAR   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_byte_rx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     due;
  } ev_t;

  ev_t        q[$];
  logic [7:0] model_data = 8'h00;
  int         total = 0;
  int         bad = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         busy_cycles = 0;
  logic       prev_strobe = 1'b0;
  int         k;
  int         ka;
  ev_t        e;

  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
    end else begin
      k = int'(rx_valid) + int'(frame_err) + int'(parity_err);
      if (busy) busy_cycles++;
      if (k != 0) begin
        total++;
        if (k != 1) begin
          bad++;
          $display("FAIL strobe_excl cyc=%0d: %0d strobes high, want 1", cyc, k);
        end
        total++;
        if (prev_strobe) begin
          bad++;
          $display("FAIL strobe_width cyc=%0d: strobe high two cycles, want one", cyc);
        end
        ka = rx_valid ? K_VALID : (frame_err ? K_FRAME : K_PAR);
        if (rx_valid) n_valid++;
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe cyc=%0d: kind %0d with nothing pending", cyc, ka);
        end else begin
          e = q.pop_front();
          total++;
          if (ka != e.kind) begin
            bad++;
            $display("FAIL strobe_kind cyc=%0d: got kind %0d want %0d", cyc, ka, e.kind);
          end
          total++;
          if (cyc < e.due - 2 || cyc > e.due + 2) begin
            bad++;
            $display("FAIL strobe_time: got cyc %0d want %0d (+-2)", cyc, e.due);
          end
          if (rx_valid && e.kind == K_VALID) model_data = e.data;
        end
      end
      prev_strobe = (k != 0);
      total++;
      if (rx_data !== model_data) begin
        bad++;
        $display("FAIL rx_data cyc=%0d: got %02h want %02h", cyc, rx_data, model_data);
      end
      if (q.size() > 0 && cyc > q[0].due + 2) begin
        total++;
        bad++;
        $display("FAIL missing_strobe: kind %0d due cyc %0d, now %0d", q[0].kind, q[0].due, cyc);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(N);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_bit, input int kind,
                      input logic par_flip);
    ev_t ev;
    logic pb;
    ev.kind = kind;
    ev.data = d;
    ev.due  = cyc + LAT;
    q.push_back(ev);
    pb = (^d) ^ par_flip;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (P == 1) drive_bit(pb);
    drive_bit(stop_bit);
  endtask

  logic [7:0] burst [13] = '{8'h52, 8'h0E, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'h55, 8'h66, 8'h77, 8'h88, 8'h64, 8'h9A};
  logic [7:0] partial = 8'h3C;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_parity_err", int'(parity_err), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    tick(5);

    // single byte
    send(8'h52, 1'b1, K_VALID, 1'b0);
    tick(3 * N);
    chk("t1_rx_data", int'(rx_data), 8'h52);
    chk("t1_valid_cnt", n_valid, 1);
    chk("t1_ferr_cnt", n_ferr, 0);
    chk("t1_busy_low", int'(busy), 0);

    // back-to-back frame with no idle gap
    for (int i = 0; i < 13; i++) send(burst[i], 1'b1, K_VALID, 1'b0);
    tick(3 * N);
    chk("t2_valid_cnt", n_valid, 14);
    chk("t2_rx_data", int'(rx_data), 8'h9A);
    chk("t2_drain", q.size(), 0);

    // short low glitch
    busy_cycles = 0;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * N);
    chk("t3_busy_pulsed", int'(busy_cycles != 0), 1);
    chk("t3_busy_short", int'(busy_cycles <= N), 1);
    chk("t3_busy_low", int'(busy), 0);
    chk("t3_valid_cnt", n_valid, 14);

    // bad stop bit (parity also wrong in 8E1 builds), line held low
    send(8'hA5, 1'b0, K_FRAME, 1'b1);
    tick(40);
    chk("t4_busy_in_break", int'(busy), 1);
    rx = 1'b1;
    tick(3 * N);
    chk("t4_ferr_cnt", n_ferr, 1);
    chk("t4_rx_data_kept", int'(rx_data), 8'h9A);
    chk("t4_valid_cnt", n_valid, 14);
    chk("t4_perr_cnt", n_perr, 0);
    send(8'h33, 1'b1, K_VALID, 1'b0);
    tick(3 * N);
    chk("t4_recover_data", int'(rx_data), 8'h33);
    chk("t4_recover_cnt", n_valid, 15);

    // reset during data bit 4 of 0x3C
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i]);
    rx = partial[4];
    tick(N / 2);
    chk("t5_busy_mid", int'(busy), 1);
    rst = 1'b1;
    model_data = 8'h00;
    q.delete();
    tick(1);
    chk("t5_reset_data", int'(rx_data), 0);
    chk("t5_reset_busy", int'(busy), 0);
    rst = 1'b0;
    rx  = 1'b1;
    tick(3 * N);
    send(8'h0E, 1'b1, K_VALID, 1'b0);
    tick(3 * N);
    chk("t5_rx_data", int'(rx_data), 8'h0E);
    chk("t5_valid_cnt", n_valid, 16);

`ifdef PARITY_EN
    send(8'h21, 1'b1, K_VALID, 1'b0);
    send(8'h0E, 1'b1, K_PAR, 1'b1);
    tick(3 * N);
    chk("t6_perr_cnt", n_perr, 1);
    chk("t6_rx_data_kept", int'(rx_data), 8'h21);
    chk("t6_valid_cnt", n_valid, 17);
    send(8'h0E, 1'b1, K_VALID, 1'b0);
    tick(3 * N);
    chk("t6_rx_data", int'(rx_data), 8'h0E);
    chk("t6_valid_cnt2", n_valid, 18);
`endif

    tick(2 * N);
    chk("final_drain", q.size(), 0);
    chk("final_busy", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
